// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
// Multiply has a fixed latency. Divide is restoring radix-2, with one setup cycle followed by WIDTH iterations.
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       md_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             ex_hold,
    input  logic             flush,
    output logic [WIDTH-1:0] md_data,
    output logic             md_stall,
    output logic             md_busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               sgn_q, sgn_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dz_q, dz_d;

    // A non-one-hot md_op decodes to no operation.
    logic op_valid;
    logic op_mult, op_multu, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo;

    assign op_valid = (md_op != 8'd0) && ((md_op & (md_op - 8'd1)) == 8'd0);
    assign op_mult  = op_valid & md_op[0];
    assign op_multu = op_valid & md_op[1];
    assign op_div   = op_valid & md_op[2];
    assign op_divu  = op_valid & md_op[3];
    assign op_mfhi  = op_valid & md_op[4];
    assign op_mflo  = op_valid & md_op[5];
    assign op_mthi  = op_valid & md_op[6];
    assign op_mtlo  = op_valid & md_op[7];

    // The multiplier reads the raw inputs in the launch cycle and the latched operands in MUL.
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_sgn;
    logic [2*WIDTH-1:0] mul_xa, mul_xb, prod;

    assign mul_a   = (state_q == S_MUL) ? op_a_q : rs_data;
    assign mul_b   = (state_q == S_MUL) ? op_b_q : rt_data;
    assign mul_sgn = (state_q == S_MUL) ? sgn_q  : op_mult;
    assign mul_xa  = mul_sgn ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
    assign mul_xb  = mul_sgn ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
    assign prod    = mul_xa * mul_xb;

    // Magnitudes for the divide setup cycle.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign a_neg = op_div & rs_data[WIDTH-1];
    assign b_neg = op_div & rt_data[WIDTH-1];
    assign a_abs = a_neg ? -rs_data : rs_data;
    assign b_abs = b_neg ? -rt_data : rt_data;

    // One restoring step: shift in the next dividend bit and subtract if the result stays non-negative.
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;

    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, op_b_q};
    assign rem_nx    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign quo_nx    = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    assign q_fin     = q_neg_q ? -quo_nx : quo_nx;
    assign r_fin     = r_neg_q ? -rem_nx : rem_nx;

    always_comb begin
        // NOTE: every signal written here is given a default first so that no path infers a latch.
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        sgn_d    = sgn_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dz_d     = dz_q;
        md_stall = 1'b0;
        md_busy  = (state_q != S_IDLE);
        md_data  = '0;

        case (state_q)
            S_IDLE: begin
                if (op_mfhi) md_data = hi_q;
                if (op_mflo) md_data = lo_q;
                if (op_mthi) hi_d = rs_data;
                if (op_mtlo) lo_d = rs_data;
                if (op_mult || op_multu) begin
                    md_stall = 1'b1;
                    if (MUL_LAT == 1) begin
                        {hi_d, lo_d} = prod;
                        state_d      = S_DONE;
                    end else begin
                        op_a_d  = rs_data;
                        op_b_d  = rt_data;
                        sgn_d   = op_mult;
                        cnt_d   = CNT_W'(MUL_LAT - 2);
                        state_d = S_MUL;
                    end
                end
                if (op_div || op_divu) begin
                    md_stall = 1'b1;
                    op_a_d   = rs_data;
                    op_b_d   = b_abs;
                    quo_d    = a_abs;
                    rem_d    = '0;
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    dz_d     = (rt_data == '0);
                    cnt_d    = CNT_W'(WIDTH - 1);
                    state_d  = S_DIV;
                end
            end
            S_MUL: begin
                md_stall = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod;
                    state_d      = S_DONE;
                end
            end
            S_DIV: begin
                md_stall = 1'b1;
                quo_d    = quo_nx;
                rem_d    = rem_nx;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // Divide by zero returns all ones in LO and the original dividend in HI.
                    lo_d    = dz_q ? '1 : q_fin;
                    hi_d    = dz_q ? op_a_q : r_fin;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (op_mfhi) md_data = hi_q;
                if (op_mflo) md_data = lo_q;
                if (!ex_hold) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush abandons the operation and any HI/LO write due at this edge.
        if (flush) begin
            state_d  = S_IDLE;
            hi_d     = hi_q;
            lo_d     = lo_q;
            md_stall = 1'b0;
        end
        if (rst) md_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples its pre-edge _d value.
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter.
// Stimulus tasks set the expected per-cycle outputs, and an arithmetic model supplies the HI/LO results.
module tb_mdu_iter;

    localparam int W   = 32;
    localparam int LAT = 4;

    localparam logic [7:0] OP_NONE  = 8'h00;
    localparam logic [7:0] OP_MULT  = 8'h01;
    localparam logic [7:0] OP_MULTU = 8'h02;
    localparam logic [7:0] OP_DIV   = 8'h04;
    localparam logic [7:0] OP_DIVU  = 8'h08;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h20;
    localparam logic [7:0] OP_MTHI  = 8'h40;
    localparam logic [7:0] OP_MTLO  = 8'h80;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   md_op;
    logic [W-1:0] rs_data, rt_data;
    logic         ex_hold, flush;
    logic [W-1:0] md_data;
    logic         md_stall, md_busy;

    mdu_iter #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .md_op    (md_op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .ex_hold  (ex_hold),
        .flush    (flush),
        .md_data  (md_data),
        .md_stall (md_stall),
        .md_busy  (md_busy)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    bit           chk_en = 1'b0;
    logic         exp_stall, exp_busy;
    logic [W-1:0] exp_data;
    logic [W-1:0] ref_hi, ref_lo;
    string        tag = "reset";

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%08h, expected 0x%08h at %0t", tag, name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("md_stall", {31'd0, md_stall}, {31'd0, exp_stall});
            check("md_busy",  {31'd0, md_busy},  {31'd0, exp_busy});
            check("md_data",  md_data, exp_data);
        end
    end

    function automatic logic [63:0] m_mul(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = longint'({32'd0, a}) * longint'({32'd0, b});
        return p;
    endfunction

    task automatic m_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa, sb, q, r;
        if (b == '0) begin
            lo = '1;
            hi = a;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q  = sa / sb;
            r  = sa % sb;
            lo = q[W-1:0];
            hi = r[W-1:0];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic s, input logic b, input logic [W-1:0] d);
        exp_stall = s;
        exp_busy  = b;
        exp_data  = d;
    endtask

    task automatic idle_cycle();
        md_op = OP_NONE; ex_hold = 1'b0; flush = 1'b0;
        expect_out(1'b0, 1'b0, '0);
        cyc();
    endtask

    task automatic read_hilo(input string name);
        tag = {name, ":mfhi"};
        md_op = OP_MFHI;
        expect_out(1'b0, 1'b0, ref_hi);
        cyc();
        tag = {name, ":mflo"};
        md_op = OP_MFLO;
        expect_out(1'b0, 1'b0, ref_lo);
        cyc();
        idle_cycle();
    endtask

    task automatic pin(input logic [W-1:0] hi_lit, input logic [W-1:0] lo_lit);
        check("model_hi", ref_hi, hi_lit);
        check("model_lo", ref_lo, lo_lit);
    endtask

    // Full multiply or divide, then `hold` extra DONE cycles with ex_hold high and the op still presented.
    task automatic run_md(input string name, input logic [7:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        int lat;
        bit is_mul;
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        lat    = is_mul ? LAT : W + 1;
        if (is_mul) {ref_hi, ref_lo} = m_mul(op == OP_MULT, a, b);
        else        m_div(op == OP_DIV, a, b, ref_hi, ref_lo);
        tag = name;
        md_op = op; rs_data = a; rt_data = b; ex_hold = 1'b0; flush = 1'b0;
        for (int i = 0; i < lat; i++) begin
            expect_out(1'b1, i != 0, '0);
            cyc();
        end
        for (int i = 0; i <= hold; i++) begin
            ex_hold = (i < hold);
            expect_out(1'b0, 1'b1, '0);
            cyc();
        end
        idle_cycle();
    endtask

    initial begin
        rst = 1'b1; md_op = OP_NONE; rs_data = '0; rt_data = '0; ex_hold = 1'b0; flush = 1'b0;
        expect_out(1'b0, 1'b0, '0);
        ref_hi = '0; ref_lo = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        idle_cycle();
        read_hilo("reset");

        run_md("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'd2, 0);
        pin(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        read_hilo("mult_neg");

        run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        pin(32'h0000_0001, 32'hFFFF_FFFE);
        read_hilo("multu");

        run_md("mult_nn", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 0);
        pin(32'h0000_0000, 32'h0000_0015);
        read_hilo("mult_nn");

        run_md("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        pin(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        read_hilo("div_neg");

        run_md("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 0);
        pin(32'h0000_0001, 32'hFFFF_FFFD);
        read_hilo("div_negb");

        run_md("divu", OP_DIVU, 32'd100, 32'd7, 0);
        pin(32'h0000_0002, 32'h0000_000E);
        read_hilo("divu");

        run_md("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 0);
        read_hilo("divu_big");

        run_md("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 0);
        pin(32'h0000_1234, 32'hFFFF_FFFF);
        read_hilo("divu_zero");

        run_md("div_zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 0);
        pin(32'hFFFF_FFFB, 32'hFFFF_FFFF);
        read_hilo("div_zero");

        run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        pin(32'h0000_0000, 32'h8000_0000);
        read_hilo("div_ovf");

        // Flush in cycle 10 of a divide: HI/LO keep the overflow result.
        tag = "div_flush";
        md_op = OP_DIV; rs_data = 32'd1000; rt_data = 32'd3;
        for (int i = 0; i < 9; i++) begin
            expect_out(1'b1, i != 0, '0);
            cyc();
        end
        flush = 1'b1;
        expect_out(1'b0, 1'b1, '0);
        cyc();
        idle_cycle();
        read_hilo("div_flush");

        // Flush on the final multiply edge wins.
        tag = "mul_flush_last";
        md_op = OP_MULTU; rs_data = 32'd5; rt_data = 32'd6;
        for (int i = 0; i < LAT - 1; i++) begin
            expect_out(1'b1, i != 0, '0);
            cyc();
        end
        flush = 1'b1;
        expect_out(1'b0, 1'b1, '0);
        cyc();
        idle_cycle();
        read_hilo("mul_flush_last");

        // Flush suppresses an MTLO.
        tag = "mtlo_flush";
        md_op = OP_MTLO; rs_data = 32'hDEAD_BEEF; flush = 1'b1;
        expect_out(1'b0, 1'b0, '0);
        cyc();
        idle_cycle();
        read_hilo("mtlo_flush");

        // A non-one-hot op is ignored.
        tag = "non_onehot";
        md_op = OP_MFHI | OP_MULTU; rs_data = 32'd9; rt_data = 32'd9;
        expect_out(1'b0, 1'b0, '0);
        cyc();
        idle_cycle();
        read_hilo("non_onehot");

        // Three held DONE cycles with the op still presented, then MTHI.
        run_md("done_hold", OP_DIVU, 32'd50, 32'd5, 3);
        pin(32'h0000_0000, 32'h0000_000A);
        tag = "mthi";
        md_op = OP_MTHI; rs_data = 32'h0000_1234;
        expect_out(1'b0, 1'b0, '0);
        cyc();
        ref_hi = 32'h0000_1234;
        read_hilo("mthi");

        // Repeated MTLO under ex_hold.
        tag = "mtlo_hold";
        md_op = OP_MTLO; rs_data = 32'h0BAD_CAFE; ex_hold = 1'b1;
        expect_out(1'b0, 1'b0, '0);
        cyc(); cyc();
        ref_lo = 32'h0BAD_CAFE;
        idle_cycle();
        read_hilo("mtlo_hold");

        // Reset in the middle of a multiply clears HI and LO.
        tag = "mul_rst";
        md_op = OP_MULT; rs_data = 32'd3; rt_data = 32'd4;
        expect_out(1'b1, 1'b0, '0);
        cyc();
        expect_out(1'b1, 1'b1, '0);
        cyc();
        chk_en = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        ref_hi = '0; ref_lo = '0;
        idle_cycle();
        read_hilo("mul_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
